eth_rx_word_packer: RTL and testbench

- Sits directly downstream of the Ethernet MAC receive port and upstream of the MPU datapath.
- Consumes the MAC's 8-bit Avalon-ST receive stream and packs it into 32-bit big-endian Avalon-ST words with SOP/EOP/empty.
- Folds per-byte error status into a single per-frame error flag on the EOP word.
- Enforces a maximum frame length, terminates frames that are interrupted by a new SOP, and keeps frame and error counters.

---
 rtl/eth_rx_word_packer.sv | 244 ++++++++++++++++++++++++
 tb/tb_eth_rx_word_packer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_word_packer.sv
// Packs the MAC 8-bit Avalon-ST receive stream into 32-bit big-endian words, folding
// per-byte errors, oversize frames and SOP-aborted frames into the EOP word's error flag.
module eth_rx_word_packer #(
   parameter int MAX_FRAME_BYTES = 1518,
   parameter int CNT_W           = 16
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_startofpacket,
   input  logic             in_endofpacket,
   input  logic [5:0]       in_error,
   input  logic [1:0]       in_empty,
   output logic [31:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_startofpacket,
   output logic             out_endofpacket,
   output logic [1:0]       out_empty,
   output logic             out_error,
   output logic [CNT_W-1:0] frame_count,
   output logic [CNT_W-1:0] err_frame_count
);

   localparam logic [15:0]      MAX_LEN = 16'(MAX_FRAME_BYTES);
   localparam logic [15:0]      LEN_SAT = 16'hFFFF;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [31:0]      acc_q, acc_d;
   logic [1:0]       idx_q, idx_d;
   logic             in_pkt_q, in_pkt_d;
   logic             sop_pend_q, sop_pend_d;
   logic             err_sticky_q, err_sticky_d;
   logic [15:0]      len_q, len_d;
   logic             emit_pend_q, emit_pend_d;
   logic [31:0]      od_q, od_d;
   logic             ov_q, ov_d;
   logic             osop_q, osop_d;
   logic             oeop_q, oeop_d;
   logic [1:0]       oempty_q, oempty_d;
   logic             oerr_q, oerr_d;
   logic [CNT_W-1:0] fcnt_q, fcnt_d;
   logic [CNT_W-1:0] ecnt_q, ecnt_d;

   logic             slot_free_s;
   logic             in_ready_s;
   logic             accept_s;
   logic             abort_s;
   logic [1:0]       idx_e_s;
   logic [15:0]      len_e_s;
   logic             err_e_s;
   logic             sop_e_s;
   logic [31:0]      acc_e_s;
   logic [31:0]      lane_s;
   logic [31:0]      word_s;
   logic             err_new_s;
   logic             last_s;
   logic             unused_s;

   assign slot_free_s = !ov_q || out_ready;
   assign in_ready_s  = slot_free_s && !emit_pend_q;
   assign accept_s    = in_valid && in_ready_s;
   assign unused_s    = ^in_empty;

   // Packing, frame tracking and output-register load decisions
   always_comb begin
      acc_d        = acc_q;
      idx_d        = idx_q;
      in_pkt_d     = in_pkt_q;
      sop_pend_d   = sop_pend_q;
      err_sticky_d = err_sticky_q;
      len_d        = len_q;
      emit_pend_d  = emit_pend_q;
      od_d         = od_q;
      ov_d         = ov_q && !out_ready;
      osop_d       = osop_q;
      oeop_d       = oeop_q;
      oempty_d     = oempty_q;
      oerr_d       = oerr_q;
      fcnt_d       = fcnt_q;
      ecnt_d       = ecnt_q;
      abort_s      = 1'b0;
      idx_e_s      = idx_q;
      len_e_s      = len_q;
      err_e_s      = err_sticky_q;
      sop_e_s      = sop_pend_q;
      acc_e_s      = acc_q;
      lane_s       = 32'h0;
      word_s       = 32'h0;
      err_new_s    = 1'b0;
      last_s       = 1'b0;

      if (emit_pend_q) begin
         // The held word is always a single-byte SOP+EOP frame that lost the slot to a terminator
         if (slot_free_s) begin
            ov_d         = 1'b1;
            od_d         = acc_q;
            osop_d       = 1'b1;
            oeop_d       = 1'b1;
            oempty_d     = 2'd3;
            oerr_d       = err_sticky_q;
            fcnt_d       = fcnt_q + CNT_ONE;
            if (err_sticky_q) begin
               ecnt_d = ecnt_q + CNT_ONE;
            end else begin
               ecnt_d = ecnt_q;
            end
            emit_pend_d  = 1'b0;
            acc_d        = 32'h0;
            err_sticky_d = 1'b0;
         end else begin
            emit_pend_d = 1'b1;
         end
      end else if (accept_s && (in_startofpacket || in_pkt_q)) begin
         if (in_startofpacket) begin
            if (in_pkt_q) begin
               abort_s = 1'b1;
               ov_d    = 1'b1;
               oeop_d  = 1'b1;
               oerr_d  = 1'b1;
               if (idx_q != 2'd0) begin
                  od_d     = acc_q;
                  oempty_d = 2'd0 - idx_q;
                  osop_d   = sop_pend_q;
               end else begin
                  od_d     = 32'h0;
                  oempty_d = 2'd3;
                  osop_d   = 1'b0;
               end
               fcnt_d = fcnt_q + CNT_ONE;
               ecnt_d = ecnt_q + CNT_ONE;
            end else begin
               abort_s = 1'b0;
            end
            idx_e_s = 2'd0;
            len_e_s = 16'd0;
            err_e_s = 1'b0;
            sop_e_s = 1'b1;
            acc_e_s = 32'h0;
         end else begin
            abort_s = 1'b0;
         end

         case (idx_e_s)
            2'd0:    lane_s = {in_data, 24'h0};
            2'd1:    lane_s = {8'h0, in_data, 16'h0};
            2'd2:    lane_s = {16'h0, in_data, 8'h0};
            2'd3:    lane_s = {24'h0, in_data};
            default: lane_s = 32'h0;
         endcase
         word_s       = acc_e_s | lane_s;
         err_new_s    = err_e_s || (in_error != 6'd0) || (len_e_s >= MAX_LEN);
         last_s       = (idx_e_s == 2'd3) || in_endofpacket;
         len_d        = (len_e_s == LEN_SAT) ? len_e_s : len_e_s + 16'd1;
         err_sticky_d = err_new_s;

         if (!last_s) begin
            acc_d      = word_s;
            idx_d      = idx_e_s + 2'd1;
            sop_pend_d = sop_e_s;
            in_pkt_d   = 1'b1;
         end else if (abort_s) begin
            acc_d       = word_s;
            idx_d       = 2'd0;
            sop_pend_d  = 1'b0;
            in_pkt_d    = 1'b0;
            emit_pend_d = 1'b1;
         end else begin
            ov_d     = 1'b1;
            od_d     = word_s;
            osop_d   = sop_e_s;
            oeop_d   = in_endofpacket;
            oempty_d = in_endofpacket ? (2'd3 - idx_e_s) : 2'd0;
            oerr_d   = in_endofpacket && err_new_s;
            if (in_endofpacket) begin
               fcnt_d = fcnt_q + CNT_ONE;
               if (err_new_s) begin
                  ecnt_d = ecnt_q + CNT_ONE;
               end else begin
                  ecnt_d = ecnt_q;
               end
            end else begin
               fcnt_d = fcnt_q;
            end
            acc_d      = 32'h0;
            idx_d      = 2'd0;
            sop_pend_d = 1'b0;
            in_pkt_d   = !in_endofpacket;
         end
      end else begin
         abort_s = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         acc_q        <= 32'h0;
         idx_q        <= 2'd0;
         in_pkt_q     <= 1'b0;
         sop_pend_q   <= 1'b0;
         err_sticky_q <= 1'b0;
         len_q        <= 16'd0;
         emit_pend_q  <= 1'b0;
         od_q         <= 32'h0;
         ov_q         <= 1'b0;
         osop_q       <= 1'b0;
         oeop_q       <= 1'b0;
         oempty_q     <= 2'd0;
         oerr_q       <= 1'b0;
         fcnt_q       <= '0;
         ecnt_q       <= '0;
      end else begin
         acc_q        <= acc_d;
         idx_q        <= idx_d;
         in_pkt_q     <= in_pkt_d;
         sop_pend_q   <= sop_pend_d;
         err_sticky_q <= err_sticky_d;
         len_q        <= len_d;
         emit_pend_q  <= emit_pend_d;
         od_q         <= od_d;
         ov_q         <= ov_d;
         osop_q       <= osop_d;
         oeop_q       <= oeop_d;
         oempty_q     <= oempty_d;
         oerr_q       <= oerr_d;
         fcnt_q       <= fcnt_d;
         ecnt_q       <= ecnt_d;
      end
   end

   assign in_ready          = in_ready_s;
   assign out_data          = od_q;
   assign out_valid         = ov_q;
   assign out_startofpacket = osop_q;
   assign out_endofpacket   = oeop_q;
   assign out_empty         = oempty_q;
   assign out_error         = oerr_q;
   assign frame_count       = fcnt_q;
   assign err_frame_count   = ecnt_q;

endmodule

// File: tb/tb_eth_rx_word_packer.sv
// Scoreboard bench: two packers (default length limit and an 8-byte limit) share one
// byte stream; a monitor checks every delivered word against hand-computed expectations.
module tb_eth_rx_word_packer;

   typedef struct {
      logic [31:0] data;
      logic        sop;
      logic        eop;
      logic [1:0]  empty;
      logic        err_a;
      logic        err_b;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_sop;
   logic        in_eop;
   logic [5:0]  in_error;
   logic [1:0]  in_empty;
   logic        out_ready;

   logic        in_ready_a, in_ready_b;
   logic [31:0] data_a, data_b;
   logic        v_a, v_b, sop_a, sop_b, eop_a, eop_b, err_a, err_b;
   logic [1:0]  emp_a, emp_b;
   logic [15:0] fc_a, fc_b, ec_a, ec_b;

   exp_t        exp_q[$];
   exp_t        e_m;
   int          n_checks = 0;
   int          n_fail = 0;
   int          stall_left = 0;
   int          exp_frames = 0;
   int          exp_err_a = 0;
   int          exp_err_b = 0;
   logic        held_v = 1'b0;
   logic [31:0] held_d = 32'h0;

   eth_rx_word_packer #(.MAX_FRAME_BYTES(1518), .CNT_W(16)) u_dut_a (
      .clk_clk(clk), .reset_reset(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_startofpacket(in_sop), .in_endofpacket(in_eop),
      .in_error(in_error), .in_empty(in_empty),
      .out_data(data_a), .out_valid(v_a), .out_ready(out_ready),
      .out_startofpacket(sop_a), .out_endofpacket(eop_a),
      .out_empty(emp_a), .out_error(err_a),
      .frame_count(fc_a), .err_frame_count(ec_a)
   );

   eth_rx_word_packer #(.MAX_FRAME_BYTES(8), .CNT_W(16)) u_dut_b (
      .clk_clk(clk), .reset_reset(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_startofpacket(in_sop), .in_endofpacket(in_eop),
      .in_error(in_error), .in_empty(in_empty),
      .out_data(data_b), .out_valid(v_b), .out_ready(out_ready),
      .out_startofpacket(sop_b), .out_endofpacket(eop_b),
      .out_empty(emp_b), .out_error(err_b),
      .frame_count(fc_b), .err_frame_count(ec_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic s, input logic e,
                       input logic [1:0] emp, input logic ea, input logic eb);
      exp_t x;
      x.data = d; x.sop = s; x.eop = e; x.empty = emp; x.err_a = ea; x.err_b = eb;
      exp_q.push_back(x);
   endtask

   // Monitor: samples mid-cycle, checks hold behaviour and pops the scoreboard on transfers
   always @(negedge clk) begin
      #3;
      if (rst) begin
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            chk("hold_data", data_a, held_d);
            chk("hold_valid", 32'(v_a), 32'd1);
         end
         chk("valid_b_matches", 32'(v_b), 32'(v_a));
         chk("in_ready_b_matches", 32'(in_ready_b), 32'(in_ready_a));
         if (v_a && !out_ready) begin
            chk("in_ready_low_on_stall", 32'(in_ready_a), 32'd0);
            held_v = 1'b1;
            held_d = data_a;
         end else begin
            held_v = 1'b0;
         end
         if (v_a && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_word: got %h expected none", data_a);
            end else begin
               e_m = exp_q.pop_front();
               chk("word_data", data_a, e_m.data);
               chk("word_sop", 32'(sop_a), 32'(e_m.sop));
               chk("word_eop", 32'(eop_a), 32'(e_m.eop));
               chk("word_empty", 32'(emp_a), 32'(e_m.empty));
               chk("word_data_b", data_b, e_m.data);
               chk("word_sop_b", 32'(sop_b), 32'(e_m.sop));
               chk("word_eop_b", 32'(eop_b), 32'(e_m.eop));
               chk("word_empty_b", 32'(emp_b), 32'(e_m.empty));
               if (e_m.eop) begin
                  chk("eop_error_a", 32'(err_a), 32'(e_m.err_a));
                  chk("eop_error_b", 32'(err_b), 32'(e_m.err_b));
               end
            end
         end
      end
   end

   task automatic cycle_start();
      @(negedge clk);
      if (stall_left > 0) begin
         out_ready = 1'b0;
         stall_left--;
      end else begin
         out_ready = 1'b1;
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic s, input logic e, input logic [5:0] er);
      int waits = 0;
      cycle_start();
      in_data = d; in_sop = s; in_eop = e; in_error = er; in_valid = 1'b1;
      #1;
      while (!in_ready_a && waits < 200) begin
         cycle_start();
         #1;
         waits++;
      end
      if (!in_ready_a) begin
         n_checks++;
         n_fail++;
         $display("FAIL in_ready_timeout: got 0 expected 1 within 200 cycles");
      end
      @(posedge clk);
   endtask

   task automatic send_run(input logic [7:0] base, input int n, input logic with_eop,
                           input int err_idx, input logic [5:0] err_val);
      for (int i = 0; i < n; i++) begin
         send_byte(base + 8'(i), i == 0, with_eop && (i == n - 1), (i == err_idx) ? err_val : 6'h0);
      end
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 300) begin
         cycle_start();
         in_valid = 1'b0;
         w++;
      end
      chk("drain_done", 32'(exp_q.size()), 32'd0);
      cycle_start();
      in_valid = 1'b0;
      cycle_start();
      #1;
   endtask

   task automatic chk_counts();
      chk("frame_count_a", 32'(fc_a), 32'(exp_frames));
      chk("frame_count_b", 32'(fc_b), 32'(exp_frames));
      chk("err_frame_count_a", 32'(ec_a), 32'(exp_err_a));
      chk("err_frame_count_b", 32'(ec_b), 32'(exp_err_b));
   endtask

   initial begin
      rst = 1'b1; in_data = 8'h0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      in_error = 6'h0; in_empty = 2'd0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 32'(v_a), 32'd0);
      chk("rst_in_ready", 32'(in_ready_a), 32'd1);
      chk("rst_out_data", data_a, 32'h0);
      chk("rst_out_sop", 32'(sop_a), 32'd0);
      chk("rst_out_eop", 32'(eop_a), 32'd0);
      chk("rst_out_empty", 32'(emp_a), 32'd0);
      chk("rst_out_error", 32'(err_a), 32'd0);
      chk_counts();

      // Bytes outside a frame are dropped; a reset mid-frame discards it
      send_byte(8'h11, 1'b0, 1'b0, 6'h0);
      send_byte(8'h12, 1'b0, 1'b1, 6'h0);
      send_byte(8'h13, 1'b1, 1'b0, 6'h0);
      send_byte(8'h14, 1'b0, 1'b0, 6'h0);
      cycle_start();
      in_valid = 1'b0;
      rst = 1'b1;
      cycle_start();
      rst = 1'b0;
      send_byte(8'h15, 1'b0, 1'b0, 6'h0);
      send_byte(8'h16, 1'b0, 1'b1, 6'h0);
      drain();
      chk("drop_no_output", 32'(v_a), 32'd0);
      chk_counts();

      // 64-byte frame 00..3F
      for (int w = 0; w < 16; w++) begin
         push({8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)}, w == 0, w == 15, 2'd0, 1'b0, 1'b1);
      end
      send_run(8'h00, 64, 1'b1, -1, 6'h0);
      drain();
      exp_frames = 1; exp_err_b = 1;
      chk_counts();

      // 5-byte frame with one-cycle latency checks
      push(32'hAABBCCDD, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      push(32'hEE000000, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
      send_byte(8'hAA, 1'b1, 1'b0, 6'h0);
      send_byte(8'hBB, 1'b0, 1'b0, 6'h0);
      send_byte(8'hCC, 1'b0, 1'b0, 6'h0);
      send_byte(8'hDD, 1'b0, 1'b0, 6'h0);
      #1;
      chk("latency_w0_valid", 32'(v_a), 32'd1);
      chk("latency_w0_data", data_a, 32'hAABBCCDD);
      send_byte(8'hEE, 1'b0, 1'b1, 6'h0);
      #1;
      chk("latency_w1_valid", 32'(v_a), 32'd1);
      chk("latency_w1_data", data_a, 32'hEE000000);
      drain();
      exp_frames = 2;

      // 12-byte frame with a 3-cycle downstream stall
      push(32'h10111213, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      push(32'h14151617, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      push(32'h18191A1B, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin
         if (i == 4) begin
            stall_left = 3;
         end
         send_byte(8'h10 + 8'(i), i == 0, i == 11, 6'h0);
      end
      drain();
      exp_frames = 3; exp_err_b = 2;
      chk_counts();

      // 8-byte frame with a MAC error on byte 2
      push(32'h20212223, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      push(32'h24252627, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
      send_run(8'h20, 8, 1'b1, 2, 6'h04);
      drain();
      exp_frames = 4; exp_err_a = 1; exp_err_b = 3;
      chk_counts();

      // Abort after 6 bytes, then a new 4-byte frame
      push(32'h01020304, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      push(32'h05060000, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1);
      push(32'h7778797A, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
      send_run(8'h01, 6, 1'b0, -1, 6'h0);
      send_run(8'h77, 4, 1'b1, -1, 6'h0);
      drain();
      exp_frames = 6; exp_err_a = 2; exp_err_b = 4;
      chk_counts();

      // Abort on a word boundary by a SOP+EOP byte: terminator, then the held word
      push(32'h30313233, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      push(32'h00000000, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1);
      push(32'h40000000, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
      send_run(8'h30, 4, 1'b0, -1, 6'h0);
      send_byte(8'h40, 1'b1, 1'b1, 6'h0);
      #1;
      chk("pending_in_ready_low", 32'(in_ready_a), 32'd0);
      drain();
      exp_frames = 8; exp_err_a = 3; exp_err_b = 5;
      chk_counts();

      // 10-byte frame (oversize only for the 8-byte limit), then an 8-byte frame
      push(32'h50515253, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      push(32'h54555657, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      push(32'h58590000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
      push(32'h60616263, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      push(32'h64656667, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
      send_run(8'h50, 10, 1'b1, -1, 6'h0);
      send_run(8'h60, 8, 1'b1, -1, 6'h0);
      drain();
      exp_frames = 10; exp_err_b = 6;
      chk_counts();

      // Standalone single-byte frame
      push(32'h9C000000, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
      send_byte(8'h9C, 1'b1, 1'b1, 6'h0);
      drain();
      exp_frames = 11;
      chk_counts();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
